// File: rtl/cache_mem_responder.sv
// Backing-memory responder for cache refill/writeback traffic.
// Accepts one line-granular request at a time through a valid/ready
// handshake, then streams LINE_WORDS refill beats after a fixed latency or
// absorbs LINE_WORDS writeback beats and reports completion after the same
// latency. Words that were never written read back as their own byte
// address, which makes refill data self-describing in cache benches.
module cache_mem_responder #(
  parameter int LINE_WORDS = 4,
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_req_valid,
  output logic        mem_req_ready,
  input  logic        mem_req_write,
  input  logic [31:0] mem_req_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_wdata_valid,
  output logic        mem_wdata_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_rdata_valid,
  output logic        mem_rdata_last,
  output logic        mem_wr_done
);

  // Beat index width, byte offset inside a line, word index width.
  localparam int BEAT_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = BEAT_W + 2;
  localparam int LINE_W = 32 - OFF_W;
  localparam int IDX_W  = $clog2(DEPTH);
  // Counter holds values 0..LATENCY-1; the +1 keeps it at least one bit wide.
  localparam int LAT_W  = $clog2(LATENCY + 1);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RLAT   = 3'd1,
    RBURST = 3'd2,
    WBURST = 3'd3,
    WLAT   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [LINE_W-1:0]   line_q, line_d;      // line-aligned request address, unwrapped
  logic [BEAT_W-1:0]   beat_q, beat_d;      // next beat to emit / absorb
  logic [LAT_W-1:0]    lat_q, lat_d;        // latency countdown
  logic                req_ready_q, req_ready_d;
  logic                wdata_ready_q, wdata_ready_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                rlast_q, rlast_d;
  logic                wr_done_q, wr_done_d;

  // Storage: the data array is deliberately not reset; the written bitmap is.
  logic [31:0]         mem_q [DEPTH];
  logic [DEPTH-1:0]    written_q;

  // Word addressed by the current beat (unwrapped) and its storage slot.
  logic [29:0]         word_s;
  logic [IDX_W-1:0]    idx_s;
  logic [31:0]         rd_word_s;
  logic                wr_en_s;
  logic                addr_unused_s;

  // The low address bits select bytes/words inside the line and are ignored.
  assign addr_unused_s = ^mem_req_addr[OFF_W-1:0];

  assign word_s    = {line_q, beat_q};
  assign idx_s     = word_s[IDX_W-1:0];
  // Unwritten words return the byte address of the beat, not the wrapped slot.
  assign rd_word_s = written_q[idx_s] ? mem_q[idx_s] : {word_s, 2'b00};
  assign wr_en_s   = (state_q == WBURST) && mem_wdata_valid;

  // Next-state and registered-output decode for the request/beat sequencer.
  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    beat_d    = beat_q;
    lat_d     = lat_q;
    rdata_d   = 32'h0000_0000;
    rvalid_d  = 1'b0;
    rlast_d   = 1'b0;
    wr_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_req_valid && req_ready_q) begin
          line_d = mem_req_addr[31:OFF_W];
          beat_d = '0;
          if (mem_req_write) begin
            state_d = WBURST;
          end else begin
            state_d = RLAT;
            lat_d   = LAT_LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end

      RLAT: begin
        if (lat_q == '0) begin
          // First beat is registered on the same edge that enters the burst.
          state_d  = RBURST;
          rvalid_d = 1'b1;
          rdata_d  = rd_word_s;
          rlast_d  = (beat_q == LAST_BEAT);
          beat_d   = beat_q + BEAT_W'(1);
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end

      RBURST: begin
        if (rlast_q) begin
          // Final beat is on the bus this cycle; ready returns after it.
          state_d = IDLE;
        end else begin
          rvalid_d = 1'b1;
          rdata_d  = rd_word_s;
          rlast_d  = (beat_q == LAST_BEAT);
          beat_d   = beat_q + BEAT_W'(1);
        end
      end

      WBURST: begin
        if (mem_wdata_valid) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) begin
            state_d = WLAT;
            lat_d   = LAT_LOAD;
          end else begin
            state_d = WBURST;
          end
        end else begin
          // Gap in the writeback stream: hold without timeout.
          state_d = WBURST;
        end
      end

      WLAT: begin
        if (lat_q == '0) begin
          wr_done_d = 1'b1;
          state_d   = IDLE;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d   = (state_d == IDLE);
    wdata_ready_d = (state_d == WBURST);
  end

  // Sequencer state and all handshake/response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      line_q        <= '0;
      beat_q        <= '0;
      lat_q         <= '0;
      req_ready_q   <= 1'b1;
      wdata_ready_q <= 1'b0;
      rdata_q       <= 32'h0000_0000;
      rvalid_q      <= 1'b0;
      rlast_q       <= 1'b0;
      wr_done_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      line_q        <= line_d;
      beat_q        <= beat_d;
      lat_q         <= lat_d;
      req_ready_q   <= req_ready_d;
      wdata_ready_q <= wdata_ready_d;
      rdata_q       <= rdata_d;
      rvalid_q      <= rvalid_d;
      rlast_q       <= rlast_d;
      wr_done_q     <= wr_done_d;
    end
  end

  // Writeback data array; contents survive reset so partial writes persist.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[idx_s] <= mem_wdata;
    end
  end

  // Per-word written flags; cleared by reset so reads fall back to the pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      written_q <= '0;
    end else if (wr_en_s) begin
      written_q[idx_s] <= 1'b1;
    end
  end

  assign mem_req_ready   = req_ready_q;
  assign mem_wdata_ready = wdata_ready_q;
  assign mem_rdata       = rdata_q;
  assign mem_rdata_valid = rvalid_q;
  assign mem_rdata_last  = rlast_q;
  assign mem_wr_done     = wr_done_q;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Scoreboard bench for cache_mem_responder: refill beats are predicted from a
// reference memory model when a read is accepted and checked (data, last flag,
// arrival cycle) when the responder emits them.
module tb_cache_mem_responder;

  localparam int LW    = 4;
  localparam int DEPTH = 1024;
  localparam int LAT   = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req_valid = 1'b0;
  logic        mem_req_ready;
  logic        mem_req_write = 1'b0;
  logic [31:0] mem_req_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic        mem_wdata_valid = 1'b0;
  logic        mem_wdata_ready;
  logic [31:0] mem_rdata;
  logic        mem_rdata_valid;
  logic        mem_rdata_last;
  logic        mem_wr_done;

  cache_mem_responder #(
    .LINE_WORDS(LW),
    .DEPTH     (DEPTH),
    .LATENCY   (LAT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_write  (mem_req_write),
    .mem_req_addr   (mem_req_addr),
    .mem_wdata      (mem_wdata),
    .mem_wdata_valid(mem_wdata_valid),
    .mem_wdata_ready(mem_wdata_ready),
    .mem_rdata      (mem_rdata),
    .mem_rdata_valid(mem_rdata_valid),
    .mem_rdata_last (mem_rdata_last),
    .mem_wr_done    (mem_wr_done)
  );

  always #5 clk = ~clk;

  // Edge counter: at a falling edge it equals the number of the last rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          cyc;
  } exp_beat_t;

  exp_beat_t exp_q[$];
  exp_beat_t mon_e;

  int n_cmp = 0;
  int n_err = 0;

  // Reference storage.
  logic [31:0] mdl_mem [DEPTH];
  bit          mdl_wr  [DEPTH];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] beat_word(input logic [31:0] addr, input int beat);
    return ((addr >> 2) & 32'(~(LW - 1))) + 32'(beat);
  endfunction

  function automatic logic [31:0] mdl_read(input logic [31:0] addr, input int beat);
    logic [31:0] w;
    int          idx;
    w   = beat_word(addr, beat);
    idx = int'(w % 32'(DEPTH));
    return mdl_wr[idx] ? mdl_mem[idx] : (w << 2);
  endfunction

  function automatic void mdl_write(input logic [31:0] addr, input int beat, input logic [31:0] data);
    int idx;
    idx = int'(beat_word(addr, beat) % 32'(DEPTH));
    mdl_mem[idx] = data;
    mdl_wr[idx]  = 1'b1;
  endfunction

  // Present a request until accepted; returns at the falling edge after the accept edge.
  task automatic do_req(input logic [31:0] addr, input logic wr, output int t_acc);
    bit acc;
    acc   = 1'b0;
    t_acc = -1;
    @(negedge clk);
    mem_req_valid = 1'b1;
    mem_req_write = wr;
    mem_req_addr  = addr;
    for (int k = 0; k < 200 && !acc; k++) begin
      if (mem_req_ready) begin
        acc   = 1'b1;
        t_acc = cyc + 1;
        if (!wr) begin
          for (int i = 0; i < LW; i++) begin
            exp_q.push_back('{data: mdl_read(addr, i), last: (i == LW - 1), cyc: t_acc + LAT + i});
          end
        end
      end
      @(negedge clk);
    end
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    if (!acc) check_eq("req_accept_timeout", {31'b0, mem_req_ready}, 32'd1);
  endtask

  task automatic do_read(input logic [31:0] addr, output int t_acc);
    do_req(addr, 1'b0, t_acc);
  endtask

  // Writeback of LW beats; gap_after >= 0 inserts one idle cycle after that beat.
  task automatic do_write(input logic [31:0] addr, input logic [32*LW-1:0] d, input int gap_after);
    int t;
    int e;
    int i;
    bit gap_done;
    bit done;
    do_req(addr, 1'b1, t);
    i        = 0;
    gap_done = 1'b0;
    for (int k = 0; k < 200 && i < LW; k++) begin
      mem_wdata_valid = 1'b1;
      mem_wdata       = d[32*i +: 32];
      if (mem_wdata_ready) begin
        mdl_write(addr, i, d[32*i +: 32]);
        i++;
      end
      @(negedge clk);
      if (gap_after >= 0 && i == gap_after + 1 && !gap_done && i < LW) begin
        gap_done        = 1'b1;
        mem_wdata_valid = 1'b0;
        @(negedge clk);
      end
    end
    mem_wdata_valid = 1'b0;
    if (i < LW) check_eq("wbeat_timeout", 32'(i), 32'(LW));
    e = cyc;
    check_eq("wready_drop", {31'b0, mem_wdata_ready}, 32'd0);
    done = 1'b0;
    for (int k = 0; k < LAT + 20 && !done; k++) begin
      if (mem_wr_done) begin
        done = 1'b1;
        check_eq("wr_done_cycle", 32'(cyc), 32'(e + LAT));
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      check_eq("wr_done_timeout", {31'b0, mem_wr_done}, 32'd1);
    end else begin
      @(negedge clk);
      check_eq("wr_done_pulse", {31'b0, mem_wr_done}, 32'd0);
    end
  endtask

  // Wait (bounded) until every predicted beat has been seen.
  task automatic drain();
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
    check_eq("drain", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  // Monitor: pop and compare every refill beat.
  always @(negedge clk) begin
    if (rst_n && mem_rdata_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_beat", {31'b0, mem_rdata_valid}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("rdata", mem_rdata, mon_e.data);
        check_eq("rlast", {31'b0, mem_rdata_last}, {31'b0, mon_e.last});
        check_eq("rbeat_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  initial begin
    int t1;
    int t2;

    // Reset state.
    repeat (3) @(negedge clk);
    check_eq("rst_req_ready",   {31'b0, mem_req_ready},   32'd1);
    check_eq("rst_wdata_ready", {31'b0, mem_wdata_ready}, 32'd0);
    check_eq("rst_rdata",       mem_rdata,                32'd0);
    check_eq("rst_rvalid",      {31'b0, mem_rdata_valid}, 32'd0);
    check_eq("rst_rlast",       {31'b0, mem_rdata_last},  32'd0);
    check_eq("rst_wr_done",     {31'b0, mem_wr_done},     32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Refill of an unwritten line, with ready tracked through the burst.
    do_read(32'h0000_0040, t1);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check_eq("ready_busy", {31'b0, mem_req_ready}, (k == 7) ? 32'd1 : 32'd0);
    end
    drain();

    // Writeback with a gap, then refill of the same line and an unaligned alias.
    do_write(32'h0000_0200, {32'h0000_0003, 32'h0000_0002, 32'h0000_0001, 32'hDEAD_BEEF}, 1);
    do_read(32'h0000_0200, t1);
    drain();
    do_read(32'h0000_020C, t1);
    drain();

    // Storage aliasing mod DEPTH; the pattern keeps the unwrapped address.
    do_write(32'h0000_1000, {32'hAAAA_0003, 32'hAAAA_0002, 32'hAAAA_0001, 32'hAAAA_0000}, -1);
    do_read(32'h0000_0000, t1);
    drain();
    do_read(32'h0000_0100, t1);
    drain();

    // Reset during refill beat 2.
    do_read(32'h0000_0200, t1);
    repeat (LAT + 2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_rvalid",      {31'b0, mem_rdata_valid}, 32'd0);
    check_eq("midrst_req_ready",   {31'b0, mem_req_ready},   32'd1);
    check_eq("midrst_rlast",       {31'b0, mem_rdata_last},  32'd0);
    check_eq("midrst_rdata",       mem_rdata,                32'd0);
    check_eq("midrst_wdata_ready", {31'b0, mem_wdata_ready}, 32'd0);
    exp_q.delete();
    for (int j = 0; j < DEPTH; j++) mdl_wr[j] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_read(32'h0000_0200, t1);
    drain();

    // Busy hold: second request waits until the cycle after rdata_last.
    do_read(32'h0000_0040, t1);
    do_read(32'h0000_0080, t2);
    check_eq("busy_accept_cycle", 32'(t2), 32'(t1 + 8));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
